// File: rtl/bus_reg_bank.sv
// Bank of NCH bus-loaded datapath registers with per-channel clear/increment, written flags and a tri-state read port.
// Loads take effect 1 edge after the strobe; bus read and contention flag are combinational. No backpressure.
module bus_reg_bank #(
    parameter int               WIDTH     = 32,
    parameter int               NCH       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               BYPASS    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NCH-1:0]   in_en,
    input  logic [1:0]       op,
    input  logic [NCH-1:0]   out_en,
    output logic [WIDTH-1:0] rdata,
    output logic [NCH-1:0]   valid,
    output logic             conflict,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;

    logic [WIDTH-1:0] chan_q [NCH];
    logic [WIDTH-1:0] chan_d [NCH];
    logic [NCH-1:0]   valid_q;
    logic [NCH-1:0]   valid_d;
    logic             err_q;
    logic             err_d;

    logic             multi_sel;
    logic             one_sel;
    logic             byp_en;
    logic [WIDTH-1:0] sel_val;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            chan_d[i] = chan_q[i];
            if (in_en[i]) begin
                case (op)
                    OP_LOAD:  chan_d[i] = wdata;
                    OP_CLEAR: chan_d[i] = '0;
                    OP_INC:   chan_d[i] = chan_q[i] + WIDTH'(1);
                    default:  chan_d[i] = chan_q[i];
                endcase
            end
        end
    end

    assign valid_d = valid_q | ((op != 2'b11) ? in_en : '0);

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign multi_sel = |(out_en & (out_en - NCH'(1)));
    assign one_sel   = (out_en != '0) && !multi_sel;

    // In reset the registers are pinned, so write-through must not expose chan_d.
    assign byp_en = (BYPASS != 0) && rst;

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (out_en[i]) begin
                sel_val = sel_val | (byp_en ? chan_d[i] : chan_q[i]);
            end
        end
    end

    assign rdata    = one_sel ? sel_val : 'z;
    assign conflict = multi_sel;

    // Contention set takes priority over a same-edge clear.
    assign err_d = multi_sel ? 1'b1 : (err_clr ? 1'b0 : err_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan_q  <= '{default: RESET_VAL};
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            chan_q  <= chan_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Scoreboarded directed bench for bus_reg_bank: one instance without and one with write-through bypass.
module tb_bus_reg_bank;

    localparam logic [31:0] RV = 32'h0000_0010;
    // Bench drives this pattern on the bus whenever the DUT must be high-Z.
    localparam logic [31:0] ZB = 32'h1234_5678;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] rd_a;
        logic [31:0] rd_b;
        logic [3:0]  vld;
        logic        cfl;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] wdata;
    logic [3:0]  in_en;
    logic [1:0]  op;
    logic [3:0]  out_en;
    logic        err_clr;
    logic        probe_en;

    wire  [31:0] rd_a;
    wire  [31:0] rd_b;
    logic [3:0]  vld_a, vld_b;
    logic        cfl_a, cfl_b;
    logic        err_a, err_b;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    assign rd_a = probe_en ? ZB : 32'bz;
    assign rd_b = probe_en ? ZB : 32'bz;

    bus_reg_bank #(.WIDTH(32), .NCH(4), .RESET_VAL(RV), .BYPASS(0)) u_dut_a (
        .clk(clk), .rst(rst), .wdata(wdata), .in_en(in_en), .op(op), .out_en(out_en),
        .rdata(rd_a), .valid(vld_a), .conflict(cfl_a), .err(err_a), .err_clr(err_clr)
    );

    bus_reg_bank #(.WIDTH(32), .NCH(4), .RESET_VAL(RV), .BYPASS(1)) u_dut_b (
        .clk(clk), .rst(rst), .wdata(wdata), .in_en(in_en), .op(op), .out_en(out_en),
        .rdata(rd_b), .valid(vld_b), .conflict(cfl_b), .err(err_b), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    // Applies one cycle of stimulus and queues the values expected before the next edge.
    task automatic step(input logic r, input logic [3:0] ie, input logic [1:0] o, input logic [31:0] wd,
                        input logic [3:0] oe, input logic ec, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [3:0] ev, input logic ecf, input logic eer);
        exp_t x;
        @(posedge clk);
        #1;
        rst      = r;
        in_en    = ie;
        op       = o;
        wdata    = wd;
        out_en   = oe;
        err_clr  = ec;
        probe_en = (oe == 4'b0000) || ((oe & (oe - 4'd1)) != 4'b0000);
        step_no++;
        x.id   = 8'(step_no);
        x.rd_a = ea;
        x.rd_b = eb;
        x.vld  = ev;
        x.cfl  = ecf;
        x.err  = eer;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(int'(e.id), "rdata_a",    rd_a,          e.rd_a);
            chk(int'(e.id), "rdata_b",    rd_b,          e.rd_b);
            chk(int'(e.id), "valid_a",    32'(vld_a),    32'(e.vld));
            chk(int'(e.id), "valid_b",    32'(vld_b),    32'(e.vld));
            chk(int'(e.id), "conflict_a", 32'(cfl_a),    32'(e.cfl));
            chk(int'(e.id), "conflict_b", 32'(cfl_b),    32'(e.cfl));
            chk(int'(e.id), "err_a",      32'(err_a),    32'(e.err));
            chk(int'(e.id), "err_b",      32'(err_b),    32'(e.err));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; in_en = '0; op = 2'b11; wdata = '0; out_en = '0; err_clr = 1'b0; probe_en = 1'b1;
        //    rst in_en   op     wdata          out_en  clr  exp_a          exp_b          valid   cfl   err
        // Reset: every channel reads RESET_VAL, strobes ignored, idle bus is Z.
        step(0, 4'b0000, 2'b11, 32'h0,         4'b0001, 0, RV,            RV,            4'b0000, 0, 0);
        step(0, 4'b1111, 2'b00, 32'hFF,        4'b1000, 0, RV,            RV,            4'b0000, 0, 0);
        step(0, 4'b0000, 2'b11, 32'h0,         4'b0000, 0, ZB,            ZB,            4'b0000, 0, 0);
        // Load / readback.
        step(1, 4'b0001, 2'b00, 32'hDEADBEEF,  4'b0001, 0, RV,            32'hDEADBEEF,  4'b0000, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0001, 0, 32'hDEADBEEF,  32'hDEADBEEF,  4'b0001, 0, 0);
        // Increment wrap on ch2.
        step(1, 4'b0100, 2'b00, 32'hFFFFFFFE,  4'b0010, 0, RV,            RV,            4'b0001, 0, 0);
        step(1, 4'b0100, 2'b10, 32'h0,         4'b0100, 0, 32'hFFFFFFFE,  32'hFFFFFFFF,  4'b0101, 0, 0);
        step(1, 4'b0100, 2'b10, 32'h0,         4'b0100, 0, 32'hFFFFFFFF,  32'h0,         4'b0101, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0100, 0, 32'h0,         32'h0,         4'b0101, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b1000, 0, RV,            RV,            4'b0101, 0, 0);
        // Multi-load then partial clear.
        step(1, 4'b1111, 2'b00, 32'h5,         4'b0001, 0, 32'hDEADBEEF,  32'h5,         4'b0101, 0, 0);
        step(1, 4'b0110, 2'b01, 32'h77,        4'b0010, 0, 32'h5,         32'h0,         4'b1111, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0001, 0, 32'h5,         32'h5,         4'b1111, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0010, 0, 32'h0,         32'h0,         4'b1111, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0100, 0, 32'h0,         32'h0,         4'b1111, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b1000, 0, 32'h5,         32'h5,         4'b1111, 0, 0);
        // Hold op leaves the channel alone, bypass shows the current value.
        step(1, 4'b0001, 2'b11, 32'h9,         4'b0001, 0, 32'h5,         32'h5,         4'b1111, 0, 0);
        // Bypass: ch1 = 7, then increment while selected.
        step(1, 4'b0010, 2'b00, 32'h7,         4'b0000, 0, ZB,            ZB,            4'b1111, 0, 0);
        step(1, 4'b0010, 2'b10, 32'h0,         4'b0010, 0, 32'h7,         32'h8,         4'b1111, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0010, 0, 32'h8,         32'h8,         4'b1111, 0, 0);
        // Contention, sticky err, set-beats-clear, then clear.
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0011, 0, ZB,            ZB,            4'b1111, 1, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0011, 1, ZB,            ZB,            4'b1111, 1, 1);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0001, 1, 32'h5,         32'h5,         4'b1111, 0, 1);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0001, 0, 32'h5,         32'h5,         4'b1111, 0, 0);
        step(1, 4'b1000, 2'b00, 32'hAA,        4'b1010, 0, ZB,            ZB,            4'b1111, 1, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b1000, 0, 32'hAA,        32'hAA,        4'b1111, 0, 1);
        // Reset mid-operation, then normal ops on the first edge after release.
        step(0, 4'b1111, 2'b10, 32'h0,         4'b1000, 0, RV,            RV,            4'b0000, 0, 0);
        step(1, 4'b0100, 2'b10, 32'h0,         4'b0100, 0, RV,            32'h11,        4'b0000, 0, 0);
        step(1, 4'b0000, 2'b11, 32'h0,         4'b0100, 0, 32'h11,        32'h11,        4'b0100, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
